// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data RAM arbiter with round-robin ties and burst lock.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 win every idle tie.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [1:0]        size0_i,
  input  logic [1:0]        size1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] wdata0_i,
  input  logic [ADDR_W-1:0] wdata1_i,
  input  logic [1:0]        lock_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [1:0]        err_o,
  output logic [ADDR_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [ADDR_W-1:0] ram_wd_o,
  output logic              ram_sb_o,
  output logic              ram_sh_o,
  output logic              ram_sw_o,
  input  logic [ADDR_W-1:0] ram_rd_i
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCKED,
    S_YIELD
  } state_e;

  state_e state_q, state_d;
  logic own_q, own_d;
  logic last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic [1:0] rvalid_q, rvalid_d;
  logic [1:0] err_q, err_d;
  logic [ADDR_W-1:0] rdata_q, rdata_d;

  logic tie, arb_w, w, gv, gnt_v;
  logic wr, aligned;
  logic [1:0] sz;
  logic [ADDR_W-1:0] a, wd;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign tie = 1'b0;
`else
  assign tie = ~last_q;
`endif

  assign arb_w = (req_i == 2'b11) ? tie : req_i[1];

  // LOCKED keeps the owner; YIELD owes the other port one grant
  always_comb begin
    w  = arb_w;
    gv = |req_i;
    unique case (1'b1)
      (state_q == S_LOCKED) && req_i[own_q]: begin
        w  = own_q;
        gv = 1'b1;
      end
      (state_q == S_YIELD) && req_i[~own_q]: begin
        w  = ~own_q;
        gv = 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt_v = gv & rst_n;

  assign a  = w ? addr1_i  : addr0_i;
  assign wd = w ? wdata1_i : wdata0_i;
  assign sz = w ? size1_i  : size0_i;
  assign wr = we_i[w];

  assign aligned = (sz == 2'b00)
                 | ((sz == 2'b01) & ~a[0])
                 | ((sz == 2'b10) & (a[1:0] == 2'b00));

  assign gnt_o    = gnt_v ? (w ? 2'b10 : 2'b01) : 2'b00;
  assign ram_a_o  = gnt_v ? a  : '0;
  assign ram_wd_o = gnt_v ? wd : '0;
  assign ram_sb_o = gnt_v & wr & aligned & (sz == 2'b00);
  assign ram_sh_o = gnt_v & wr & aligned & (sz == 2'b01);
  assign ram_sw_o = gnt_v & wr & aligned & (sz == 2'b10);

  always_comb begin
    state_d  = S_IDLE;
    own_d    = own_q;
    last_d   = last_q;
    cnt_d    = '0;
    cnt_n    = CW'(1);
    rvalid_d = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    if ((state_q == S_LOCKED) && (w == own_q))
      cnt_n = cnt_q + 1'b1;
    if (gnt_v) begin
      last_d = w;
      if (lock_i[w]) begin
        own_d = w;
        if (cnt_n >= CW'(MAX_LOCK)) begin
          state_d = S_YIELD;
        end else begin
          state_d = S_LOCKED;
          cnt_d   = cnt_n;
        end
      end
      if (!aligned) begin
        rvalid_d[w] = 1'b1;
        err_d[w]    = 1'b1;
      end else if (!wr) begin
        rvalid_d[w] = 1'b1;
        rdata_d     = ram_rd_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      own_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule
